// File: rtl/vx_cluster_gbar.sv
// Cluster-level global barrier unit: collects per-socket arrivals for each barrier ID and
// emits one release (ID + arrival mask) through a single-entry response register.
module vx_cluster_gbar #(
    parameter int NUM_SOCKETS  = 4,
    parameter int NUM_BARRIERS = 8,
    localparam int BAR_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    localparam int SCK_W = (NUM_SOCKETS > 1) ? $clog2(NUM_SOCKETS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    input  logic [BAR_W-1:0]       req_id,
    input  logic [SCK_W-1:0]       req_size_m1,
    input  logic [SCK_W-1:0]       req_socket,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [BAR_W-1:0]       rsp_id,
    output logic [NUM_SOCKETS-1:0] rsp_mask,
    input  logic                   rsp_ready,
    output logic                   err_dup,
    output logic                   err_size,
    output logic                   busy
);

    localparam logic [SCK_W:0] NS = (SCK_W+1)'(NUM_SOCKETS);
    localparam logic [BAR_W:0] NB = (BAR_W+1)'(NUM_BARRIERS);

    // Reset asserts asynchronously and releases two clocks after reset_n rises.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    logic [NUM_SOCKETS-1:0] mask_q  [NUM_BARRIERS];
    logic [SCK_W:0]         count_q [NUM_BARRIERS];
    logic [SCK_W-1:0]       size_q  [NUM_BARRIERS];

    logic [BAR_W-1:0]       idx;
    logic [NUM_SOCKETS-1:0] mask_cur;
    logic [NUM_SOCKETS-1:0] bit_vec;
    logic [SCK_W:0]         count_cur;
    logic                   id_ok, sock_ok, size_ok, armed;
    logic                   dup_hit, size_hit, accept, legal, complete, fire;
    logic                   any_armed;

    always_comb begin
        id_ok     = ({1'b0, req_id} < NB);
        sock_ok   = ({1'b0, req_socket} < NS);
        size_ok   = ({1'b0, req_size_m1} < NS);
        idx       = id_ok ? req_id : '0;
        mask_cur  = mask_q[idx];
        count_cur = count_q[idx];
        armed     = |mask_cur;
        bit_vec   = sock_ok ? (NUM_SOCKETS'(1) << req_socket) : '0;
        dup_hit   = |(mask_cur & bit_vec);
        size_hit  = !id_ok || !sock_ok || !size_ok || (armed && (req_size_m1 != size_q[idx]));
        req_ready = rst_n_int && (!rsp_valid || rsp_ready);
        accept    = req_valid && req_ready;
        legal     = !dup_hit && !size_hit;
        // Arrivals so far equal size_m1 means this arrival is the last one.
        complete  = (count_cur == {1'b0, req_size_m1});
        fire      = accept && legal && complete;
        any_armed = 1'b0;
        for (int unsigned i = 0; i < NUM_BARRIERS; i++) any_armed = any_armed | (|mask_q[i]);
        busy      = any_armed || rsp_valid;
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            for (int unsigned i = 0; i < NUM_BARRIERS; i++) begin
                mask_q[i]  <= '0;
                count_q[i] <= '0;
                size_q[i]  <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_mask  <= '0;
            err_dup   <= 1'b0;
            err_size  <= 1'b0;
        end else begin
            if (accept && legal) begin
                if (complete) begin
                    mask_q[idx]  <= '0;
                    count_q[idx] <= '0;
                end else begin
                    mask_q[idx]  <= mask_cur | bit_vec;
                    count_q[idx] <= count_cur + (SCK_W+1)'(1);
                    if (!armed) size_q[idx] <= req_size_m1;
                end
            end
            // A new release overrides the drain so back-to-back releases keep rsp_valid high.
            if (fire) begin
                rsp_valid <= 1'b1;
                rsp_id    <= req_id;
                rsp_mask  <= mask_cur | bit_vec;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            err_dup  <= err_dup  | (accept && dup_hit);
            err_size <= err_size | (accept && size_hit);
        end
    end

endmodule

// File: tb/tb_vx_cluster_gbar.sv
// Directed bench for vx_cluster_gbar with 4 sockets and 8 barrier IDs.
module tb_vx_cluster_gbar;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [2:0] req_id;
    logic [1:0] req_size_m1;
    logic [1:0] req_socket;
    logic       req_ready;
    logic       rsp_valid;
    logic [2:0] rsp_id;
    logic [3:0] rsp_mask;
    logic       rsp_ready;
    logic       err_dup;
    logic       err_size;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    vx_cluster_gbar #(.NUM_SOCKETS(4), .NUM_BARRIERS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_id(req_id), .req_size_m1(req_size_m1),
        .req_socket(req_socket), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_mask(rsp_mask), .rsp_ready(rsp_ready),
        .err_dup(err_dup), .err_size(err_size), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] id, input logic [1:0] sz,
                         input logic [1:0] sk);
        req_valid   = v;
        req_id      = id;
        req_size_m1 = sz;
        req_socket  = sk;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [2:0] id, input logic [3:0] m);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
        chk({tag, "_mask"},  32'(rsp_mask),  32'(m));
    endtask

    initial begin
        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 3'd0, 2'd0, 2'd0);
        tick();
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_err_dup",   32'(err_dup),   32'd0);
        chk("rst_err_size",  32'(err_size),  32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Four-socket barrier on ID 3, arrivals 0,2,1,3 back to back.
        drive(1'b1, 3'd3, 2'd3, 2'd0); tick();
        chk("b3_a0_valid", 32'(rsp_valid), 32'd0);
        chk("b3_a0_busy",  32'(busy),      32'd1);
        drive(1'b1, 3'd3, 2'd3, 2'd2); tick();
        drive(1'b1, 3'd3, 2'd3, 2'd1); tick();
        chk("b3_a2_valid", 32'(rsp_valid), 32'd0);
        drive(1'b1, 3'd3, 2'd3, 2'd3); tick();
        chk_rsp("b3_rel", 3'd3, 4'b1111);
        drive(1'b0, 3'd0, 2'd0, 2'd0); tick();
        chk("b3_after_valid", 32'(rsp_valid), 32'd0);
        chk("b3_after_busy",  32'(busy),      32'd0);

        // Duplicate arrival on ID 0.
        drive(1'b1, 3'd0, 2'd1, 2'd1); tick();
        drive(1'b1, 3'd0, 2'd1, 2'd1); tick();
        chk("dup_err",   32'(err_dup),   32'd1);
        chk("dup_valid", 32'(rsp_valid), 32'd0);
        chk("dup_esize", 32'(err_size),  32'd0);
        drive(1'b1, 3'd0, 2'd1, 2'd0); tick();
        chk_rsp("dup_rel", 3'd0, 4'b0011);
        drive(1'b0, 3'd0, 2'd0, 2'd0); tick();

        // Size mismatch on ID 2 is dropped.
        drive(1'b1, 3'd2, 2'd1, 2'd0); tick();
        drive(1'b1, 3'd2, 2'd2, 2'd1); tick();
        chk("sz_err",   32'(err_size),  32'd1);
        chk("sz_valid", 32'(rsp_valid), 32'd0);
        chk("sz_busy",  32'(busy),      32'd1);
        drive(1'b1, 3'd2, 2'd1, 2'd1); tick();
        chk_rsp("sz_rel", 3'd2, 4'b0011);
        chk("dup_sticky", 32'(err_dup), 32'd1);
        drive(1'b0, 3'd0, 2'd0, 2'd0); tick();

        // Held release of ID 1 stalls the completing arrival for ID 5.
        drive(1'b1, 3'd5, 2'd1, 2'd2); tick();
        rsp_ready = 1'b0;
        drive(1'b1, 3'd1, 2'd1, 2'd0); tick();
        drive(1'b1, 3'd1, 2'd1, 2'd1); tick();
        chk_rsp("hold_rel1", 3'd1, 4'b0011);
        drive(1'b1, 3'd5, 2'd1, 2'd3); #1;
        chk("hold_ready0", 32'(req_ready), 32'd0);
        tick();
        tick();
        chk_rsp("hold_stable", 3'd1, 4'b0011);
        chk("hold_ready1", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1; #1;
        chk("hold_ready2", 32'(req_ready), 32'd1);
        tick();
        chk_rsp("hold_rel5", 3'd5, 4'b1100);
        drive(1'b0, 3'd0, 2'd0, 2'd0); tick();
        chk("hold_drain", 32'(rsp_valid), 32'd0);
        chk("hold_busy",  32'(busy),      32'd0);

        // Single-socket barrier, then back-to-back releases on the same ID.
        drive(1'b1, 3'd6, 2'd0, 2'd2); tick();
        chk_rsp("s0_rel", 3'd6, 4'b0100);
        drive(1'b1, 3'd7, 2'd0, 2'd0); tick();
        chk_rsp("b2b_a", 3'd7, 4'b0001);
        drive(1'b1, 3'd7, 2'd0, 2'd1); tick();
        chk_rsp("b2b_b", 3'd7, 4'b0010);
        drive(1'b1, 3'd7, 2'd1, 2'd1); tick();
        chk("fresh_valid", 32'(rsp_valid), 32'd0);
        drive(1'b1, 3'd7, 2'd1, 2'd0); tick();
        chk_rsp("fresh_rel", 3'd7, 4'b0011);
        drive(1'b0, 3'd0, 2'd0, 2'd0); tick();

        // Reset in the middle of a three-socket barrier on ID 4.
        drive(1'b1, 3'd4, 2'd2, 2'd0); tick();
        drive(1'b1, 3'd4, 2'd2, 2'd1); tick();
        drive(1'b0, 3'd0, 2'd0, 2'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0; #1;
        chk("mid_rst_busy",  32'(busy),     32'd0);
        chk("mid_rst_edup",  32'(err_dup),  32'd0);
        chk("mid_rst_esize", 32'(err_size), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("mid_ready", 32'(req_ready), 32'd1);
        drive(1'b1, 3'd4, 2'd2, 2'd0); tick();
        drive(1'b1, 3'd4, 2'd2, 2'd1); tick();
        chk("mid_a1_valid", 32'(rsp_valid), 32'd0);
        chk("mid_a1_edup",  32'(err_dup),   32'd0);
        drive(1'b1, 3'd4, 2'd2, 2'd2); tick();
        chk_rsp("mid_rel", 3'd4, 4'b0111);
        drive(1'b0, 3'd0, 2'd0, 2'd0); tick();
        chk("end_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
